// File: rtl/layered_renderer.sv
// Layered pixel renderer: composites double-buffered rectangle objects over a
// brick bitmap and reports the first ball-to-brick overlap of each frame.
module layered_renderer #(
    parameter int unsigned NUM_OBJ     = 4,
    parameter int unsigned SEL_W       = 2,
    parameter int unsigned ROWS        = 8,
    parameter int unsigned COLS        = 16,
    parameter int unsigned BRICK_X0    = 64,
    parameter int unsigned BRICK_Y0    = 96,
    parameter int unsigned BW_LOG2     = 5,
    parameter int unsigned BH_LOG2     = 3,
    parameter int unsigned ACTIVE_W    = 800,
    parameter int unsigned ACTIVE_H    = 600,
    parameter logic [7:0]  BRICK_COLOR = 8'hE0,
    parameter logic [7:0]  BG_COLOR    = 8'h00
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [9:0]               X_PIXEL,
    input  logic [9:0]               Y_PIXEL,
    input  logic                     OBJ_WE,
    input  logic [SEL_W-1:0]         OBJ_SEL,
    input  logic [9:0]               OBJ_X,
    input  logic [9:0]               OBJ_Y,
    input  logic [9:0]               OBJ_W,
    input  logic [9:0]               OBJ_H,
    input  logic [7:0]               OBJ_COLOR,
    input  logic                     OBJ_EN,
    input  logic                     BRICK_CLR,
    input  logic [$clog2(ROWS)-1:0]  BRICK_ROW,
    input  logic [$clog2(COLS)-1:0]  BRICK_COL,
    input  logic                     BRICK_RESTORE,
    output logic [7:0]               COLOR_OUT,
    output logic                     FRAME_DONE,
    output logic                     HIT_VALID,
    output logic [$clog2(ROWS)-1:0]  HIT_ROW,
    output logic [$clog2(COLS)-1:0]  HIT_COL
);

    localparam int unsigned RW  = $clog2(ROWS);
    localparam int unsigned CW  = $clog2(COLS);
    localparam int unsigned CFW = 10 - BW_LOG2;
    localparam int unsigned RFW = 10 - BH_LOG2;

    typedef struct packed {
        logic       en;
        logic [7:0] color;
        logic [9:0] h;
        logic [9:0] w;
        logic [9:0] y;
        logic [9:0] x;
    } obj_t;

    obj_t                       shadow_q [NUM_OBJ];
    obj_t                       active_q [NUM_OBJ];
    obj_t                       obj_wr_c;
    logic [ROWS-1:0][COLS-1:0]  bitmap_q;

    logic                       commit_c;
    logic [NUM_OBJ-1:0]         hit_vec_c;
    logic [9:0]                 dx_c;
    logic [9:0]                 dy_c;
    logic [CFW-1:0]             col_full_c;
    logic [RFW-1:0]             row_full_c;
    logic [RW-1:0]              row_c;
    logic [CW-1:0]              col_c;
    logic                       brick_c;
    logic                       vis_c;

    logic [NUM_OBJ-1:0]         hit_vec_q;
    logic                       brick_q;
    logic                       vis_q;
    logic [RW-1:0]              row_q;
    logic [CW-1:0]              col_q;

    logic [7:0]                 color_c;
    logic                       ball_hit_c;
    logic                       pend_q;
    logic [RW-1:0]              pend_row_q;
    logic [CW-1:0]              pend_col_q;

    // Frame boundary: the pixel just past the last visible line
    assign commit_c = (X_PIXEL == 10'd0) && (Y_PIXEL == 10'(ACTIVE_H));

    // Assemble the write payload from the object ports
    always_comb begin
        obj_wr_c       = '0;
        obj_wr_c.en    = OBJ_EN;
        obj_wr_c.color = OBJ_COLOR;
        obj_wr_c.h     = OBJ_H;
        obj_wr_c.w     = OBJ_W;
        obj_wr_c.y     = OBJ_Y;
        obj_wr_c.x     = OBJ_X;
    end

    // Shadow writes and atomic shadow-to-active copy at the commit edge
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int unsigned i = 0; i < NUM_OBJ; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_OBJ; i++) begin
                if (OBJ_WE && (32'(OBJ_SEL) == i)) shadow_q[i] <= obj_wr_c;
                if (commit_c)                      active_q[i] <= shadow_q[i];
            end
        end
    end

    // Brick bitmap: restore beats clear
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bitmap_q <= '1;
        end else if (BRICK_RESTORE) begin
            bitmap_q <= '1;
        end else if (BRICK_CLR) begin
            bitmap_q[BRICK_ROW][BRICK_COL] <= 1'b0;
        end
    end

    // Per-slot rectangle test; upper bounds use 11-bit sums to avoid wrap
    always_comb begin
        hit_vec_c = '0;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            hit_vec_c[i] = active_q[i].en
                && (X_PIXEL >= active_q[i].x)
                && ({1'b0, X_PIXEL} < ({1'b0, active_q[i].x} + {1'b0, active_q[i].w}))
                && (Y_PIXEL >= active_q[i].y)
                && ({1'b0, Y_PIXEL} < ({1'b0, active_q[i].y} + {1'b0, active_q[i].h}));
        end
    end

    // Brick cell lookup and visibility for the sampled pixel
    always_comb begin
        dx_c       = X_PIXEL - 10'(BRICK_X0);
        dy_c       = Y_PIXEL - 10'(BRICK_Y0);
        col_full_c = dx_c[9:BW_LOG2];
        row_full_c = dy_c[9:BH_LOG2];
        col_c      = CW'(col_full_c);
        row_c      = RW'(row_full_c);
        brick_c    = (X_PIXEL >= 10'(BRICK_X0)) && (Y_PIXEL >= 10'(BRICK_Y0))
                     && (32'(col_full_c) < COLS) && (32'(row_full_c) < ROWS)
                     && bitmap_q[row_c][col_c];
        vis_c      = (X_PIXEL < 10'(ACTIVE_W)) && (Y_PIXEL < 10'(ACTIVE_H));
    end

    // Stage 1: register hit vector, brick flag and cell indices
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hit_vec_q <= '0;
            brick_q   <= 1'b0;
            vis_q     <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
        end else begin
            hit_vec_q <= hit_vec_c;
            brick_q   <= brick_c;
            vis_q     <= vis_c;
            row_q     <= row_c;
            col_q     <= col_c;
        end
    end

    // Priority compositor: lowest-index hitting slot, then brick, then background
    always_comb begin
        color_c = brick_q ? BRICK_COLOR : BG_COLOR;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (hit_vec_q[i]) color_c = active_q[i].color;
        end
    end

    // Stage 2: register the output colour, blank outside the visible area
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            COLOR_OUT <= 8'h00;
        end else begin
            COLOR_OUT <= vis_q ? color_c : 8'h00;
        end
    end

    assign ball_hit_c = vis_q && hit_vec_q[0] && brick_q;

    // First ball-to-brick hit per frame, published at the frame boundary
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            FRAME_DONE <= 1'b0;
            HIT_VALID  <= 1'b0;
            HIT_ROW    <= '0;
            HIT_COL    <= '0;
            pend_q     <= 1'b0;
            pend_row_q <= '0;
            pend_col_q <= '0;
        end else begin
            FRAME_DONE <= commit_c;
            HIT_VALID  <= 1'b0;
            if (commit_c) begin
                HIT_VALID <= pend_q;
                if (pend_q) begin
                    HIT_ROW <= pend_row_q;
                    HIT_COL <= pend_col_q;
                end
                pend_q <= 1'b0;
            end else if (ball_hit_c && !pend_q) begin
                pend_q     <= 1'b1;
                pend_row_q <= row_q;
                pend_col_q <= col_q;
            end
        end
    end

endmodule

// File: tb/tb_layered_renderer.sv
// Randomized self-checking bench for layered_renderer against a behavioural model.
module tb_layered_renderer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [9:0] X_PIXEL, Y_PIXEL;
    logic       OBJ_WE;
    logic [1:0] OBJ_SEL;
    logic [9:0] OBJ_X, OBJ_Y, OBJ_W, OBJ_H;
    logic [7:0] OBJ_COLOR;
    logic       OBJ_EN;
    logic       BRICK_CLR;
    logic [2:0] BRICK_ROW;
    logic [3:0] BRICK_COL;
    logic       BRICK_RESTORE;
    logic [7:0] COLOR_OUT;
    logic       FRAME_DONE;
    logic       HIT_VALID;
    logic [2:0] HIT_ROW;
    logic [3:0] HIT_COL;

    always #5 CLK = ~CLK;

    layered_renderer dut (
        .CLK(CLK), .RESET(RESET), .X_PIXEL(X_PIXEL), .Y_PIXEL(Y_PIXEL),
        .OBJ_WE(OBJ_WE), .OBJ_SEL(OBJ_SEL), .OBJ_X(OBJ_X), .OBJ_Y(OBJ_Y),
        .OBJ_W(OBJ_W), .OBJ_H(OBJ_H), .OBJ_COLOR(OBJ_COLOR), .OBJ_EN(OBJ_EN),
        .BRICK_CLR(BRICK_CLR), .BRICK_ROW(BRICK_ROW), .BRICK_COL(BRICK_COL),
        .BRICK_RESTORE(BRICK_RESTORE), .COLOR_OUT(COLOR_OUT),
        .FRAME_DONE(FRAME_DONE), .HIT_VALID(HIT_VALID),
        .HIT_ROW(HIT_ROW), .HIT_COL(HIT_COL)
    );

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model state
    int  sh_x[4], sh_y[4], sh_w[4], sh_h[4], sh_c[4];
    bit  sh_en[4];
    int  ac_x[4], ac_y[4], ac_w[4], ac_h[4], ac_c[4];
    bit  ac_en[4];
    bit  bm[8][16];
    bit  m_pend;
    int  m_prow, m_pcol, m_hrow, m_hcol;
    bit  m_hv;

    int         px_x[$], px_y[$];
    logic [7:0] obs[$];

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            sh_x[i] = 0; sh_y[i] = 0; sh_w[i] = 0; sh_h[i] = 0; sh_c[i] = 0; sh_en[i] = 0;
            ac_x[i] = 0; ac_y[i] = 0; ac_w[i] = 0; ac_h[i] = 0; ac_c[i] = 0; ac_en[i] = 0;
        end
        for (int r = 0; r < 8; r++) for (int c = 0; c < 16; c++) bm[r][c] = 1'b1;
        m_pend = 0; m_prow = 0; m_pcol = 0; m_hrow = 0; m_hcol = 0; m_hv = 0;
    endfunction

    function automatic void model_commit();
        for (int i = 0; i < 4; i++) begin
            ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_w[i] = sh_w[i];
            ac_h[i] = sh_h[i]; ac_c[i] = sh_c[i]; ac_en[i] = sh_en[i];
        end
        m_hv = m_pend;
        if (m_pend) begin m_hrow = m_prow; m_hcol = m_pcol; end
        m_pend = 0;
    endfunction

    function automatic bit ref_brick(int x, int y);
        int c, r;
        if (x < 64 || y < 96) return 1'b0;
        c = (x - 64) / 32;
        r = (y - 96) / 8;
        if (c >= 16 || r >= 8) return 1'b0;
        return bm[r][c];
    endfunction

    function automatic bit in_slot(int i, int x, int y);
        return ac_en[i] && x >= ac_x[i] && x < ac_x[i] + ac_w[i]
                        && y >= ac_y[i] && y < ac_y[i] + ac_h[i];
    endfunction

    function automatic logic [7:0] ref_color(int x, int y);
        if (x >= 800 || y >= 600) return 8'h00;
        for (int i = 0; i < 4; i++) if (in_slot(i, x, y)) return 8'(ac_c[i]);
        if (ref_brick(x, y)) return 8'hE0;
        return 8'h00;
    endfunction

    function automatic void hit_step(int x, int y);
        if (x < 800 && y < 600 && in_slot(0, x, y) && ref_brick(x, y) && !m_pend) begin
            m_pend = 1; m_prow = (y - 96) / 8; m_pcol = (x - 64) / 32;
        end
    endfunction

    task automatic set_filler();
        X_PIXEL = 10'd900; Y_PIXEL = 10'd650;
    endtask

    task automatic write_obj(int sel, int x, int y, int w, int h, int c, bit en);
        OBJ_SEL = 2'(sel); OBJ_X = 10'(x); OBJ_Y = 10'(y); OBJ_W = 10'(w); OBJ_H = 10'(h);
        OBJ_COLOR = 8'(c); OBJ_EN = en; OBJ_WE = 1'b1;
        set_filler();
        @(posedge CLK); #1;
        OBJ_WE = 1'b0;
        sh_x[sel] = x; sh_y[sel] = y; sh_w[sel] = w; sh_h[sel] = h; sh_c[sel] = c; sh_en[sel] = en;
    endtask

    task automatic brick_op(bit clr, bit rst_all, int r, int c);
        BRICK_CLR = clr; BRICK_RESTORE = rst_all; BRICK_ROW = 3'(r); BRICK_COL = 4'(c);
        set_filler();
        @(posedge CLK); #1;
        BRICK_CLR = 1'b0; BRICK_RESTORE = 1'b0;
        if (rst_all) begin
            for (int rr = 0; rr < 8; rr++) for (int cc = 0; cc < 16; cc++) bm[rr][cc] = 1'b1;
        end else if (clr) begin
            bm[r][c] = 1'b0;
        end
    endtask

    // Drive the queued pixels one per cycle and capture the colour two cycles later
    task automatic run_pixels();
        int n;
        n = px_x.size();
        obs.delete();
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin X_PIXEL = 10'(px_x[i]); Y_PIXEL = 10'(px_y[i]); end
            else set_filler();
            @(posedge CLK); #1;
            if (i >= 1) obs.push_back(COLOR_OUT);
        end
        set_filler();
    endtask

    // Present the frame-boundary pixel and capture the boundary outputs
    task automatic commit_frame(output logic fd1, output logic fd2, output logic hv,
                                output logic [2:0] hr, output logic [3:0] hc);
        X_PIXEL = 10'd0; Y_PIXEL = 10'd600;
        @(posedge CLK); #1;
        fd1 = FRAME_DONE; hv = HIT_VALID; hr = HIT_ROW; hc = HIT_COL;
        set_filler();
        @(posedge CLK); #1;
        fd2 = FRAME_DONE;
        model_commit();
    endtask

    task automatic add_px(int x, int y);
        px_x.push_back(x); px_y.push_back(y);
    endtask

    task automatic add_rand(int n, bit visible_only);
        int x, y;
        for (int i = 0; i < n; i++) begin
            if (visible_only) begin x = $urandom_range(0, 799); y = $urandom_range(0, 599); end
            else begin x = $urandom_range(0, 1023); y = $urandom_range(0, 1023); end
            if (x == 0 && y == 600) y = 601;
            add_px(x, y);
        end
    endtask

    task automatic add_rect(int x0, int y0, int x1, int y1);
        for (int y = y0; y <= y1; y++) for (int x = x0; x <= x1; x++) add_px(x, y);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_total++; if (COLOR_OUT !== 8'h00) $display("FAIL reset_color got %h want 00", COLOR_OUT); else n_pass++;
        n_total++; if (FRAME_DONE !== 1'b0) $display("FAIL reset_fd got %b want 0", FRAME_DONE); else n_pass++;
        n_total++; if (HIT_VALID !== 1'b0) $display("FAIL reset_hv got %b want 0", HIT_VALID); else n_pass++;
        n_total++; if (HIT_ROW !== 3'd0) $display("FAIL reset_row got %0d want 0", HIT_ROW); else n_pass++;
        n_total++; if (HIT_COL !== 4'd0) $display("FAIL reset_col got %0d want 0", HIT_COL); else n_pass++;
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic test_empty_frame();
        logic fd1, fd2, hv; logic [2:0] hr; logic [3:0] hc; logic [7:0] e;
        px_x.delete(); px_y.delete();
        add_px(63, 96); add_px(64, 96); add_px(575, 159); add_px(576, 159);
        add_px(64, 160); add_px(64, 95); add_px(799, 599); add_px(800, 100); add_px(100, 600);
        add_rand(150, 1); add_rand(30, 0);
        run_pixels();
        for (int k = 0; k < px_x.size(); k++) begin
            e = ref_color(px_x[k], px_y[k]); hit_step(px_x[k], px_y[k]);
            n_total++;
            if (obs[k] !== e) $display("FAIL empty_px (%0d,%0d) got %h want %h", px_x[k], px_y[k], obs[k], e);
            else n_pass++;
        end
        commit_frame(fd1, fd2, hv, hr, hc);
        n_total++; if (fd1 !== 1'b1) $display("FAIL empty_fd got %b want 1", fd1); else n_pass++;
        n_total++; if (fd2 !== 1'b0) $display("FAIL empty_fd_pulse got %b want 0", fd2); else n_pass++;
        n_total++; if (hv !== 1'b0) $display("FAIL empty_hv got %b want 0", hv); else n_pass++;
    endtask

    task automatic test_obj_midframe();
        logic fd1, fd2, hv; logic [2:0] hr; logic [3:0] hc; logic [7:0] e;
        write_obj(1, 100, 100, 8, 8, 8'h1C, 1'b1);
        for (int pass = 0; pass < 2; pass++) begin
            px_x.delete(); px_y.delete();
            add_rect(99, 99, 108, 108); add_rand(40, 1);
            run_pixels();
            for (int k = 0; k < px_x.size(); k++) begin
                e = ref_color(px_x[k], px_y[k]); hit_step(px_x[k], px_y[k]);
                n_total++;
                if (obs[k] !== e) $display("FAIL slot1_px%0d (%0d,%0d) got %h want %h", pass, px_x[k], px_y[k], obs[k], e);
                else n_pass++;
            end
            // (100,100) is index 11, (108,100) is index 19 of the rectangle sweep
            n_total++;
            if (obs[11] !== (pass == 0 ? 8'hE0 : 8'h1C)) $display("FAIL slot1_corner%0d got %h", pass, obs[11]);
            else n_pass++;
            n_total++; if (obs[19] !== 8'hE0) $display("FAIL slot1_edge%0d got %h want e0", pass, obs[19]); else n_pass++;
            commit_frame(fd1, fd2, hv, hr, hc);
            n_total++; if (fd1 !== 1'b1) $display("FAIL slot1_fd got %b want 1", fd1); else n_pass++;
        end
    endtask

    task automatic test_priority();
        logic fd1, fd2, hv; logic [2:0] hr; logic [3:0] hc; logic [7:0] e;
        write_obj(0, 196, 296, 8, 8, 8'hFF, 1'b1);
        write_obj(1, 200, 300, 8, 8, 8'h03, 1'b1);
        commit_frame(fd1, fd2, hv, hr, hc);
        for (int pass = 0; pass < 3; pass++) begin
            if (pass == 1) write_obj(0, 196, 296, 8, 8, 8'hFF, 1'b0);
            if (pass == 2) commit_frame(fd1, fd2, hv, hr, hc);
            px_x.delete(); px_y.delete();
            add_px(200, 300); add_rect(195, 295, 208, 308);
            run_pixels();
            for (int k = 0; k < px_x.size(); k++) begin
                e = ref_color(px_x[k], px_y[k]); hit_step(px_x[k], px_y[k]);
                n_total++;
                if (obs[k] !== e) $display("FAIL prio_px%0d (%0d,%0d) got %h want %h", pass, px_x[k], px_y[k], obs[k], e);
                else n_pass++;
            end
            n_total++;
            if (obs[0] !== (pass < 2 ? 8'hFF : 8'h03)) $display("FAIL prio_overlap%0d got %h", pass, obs[0]);
            else n_pass++;
        end
        commit_frame(fd1, fd2, hv, hr, hc);
        n_total++; if (hv !== 1'(m_hv)) $display("FAIL prio_hv got %b want %b", hv, m_hv); else n_pass++;
    endtask

    task automatic test_hit();
        logic fd1, fd2, hv; logic [2:0] hr; logic [3:0] hc; logic [7:0] e;
        int bx, by, bw, bh;
        write_obj(1, 0, 0, 0, 0, 0, 1'b0);
        write_obj(0, 96, 96, 4, 4, 8'hFF, 1'b1);
        commit_frame(fd1, fd2, hv, hr, hc);
        for (int round = 0; round < 6; round++) begin
            if (round == 1) brick_op(1'b1, 1'b0, 0, 1);
            if (round >= 2) begin
                for (int j = 0; j < 20; j++) brick_op(1'b1, 1'b0, $urandom_range(0, 7), $urandom_range(0, 15));
                bx = $urandom_range(40, 600); by = $urandom_range(80, 170);
                bw = $urandom_range(1, 12); bh = $urandom_range(1, 12);
                write_obj(0, bx, by, bw, bh, 8'hFF, 1'b1);
                commit_frame(fd1, fd2, hv, hr, hc);
            end else begin
                bx = 96; by = 96; bw = 4; bh = 4;
            end
            px_x.delete(); px_y.delete();
            add_rand(10, 1); add_rect(bx, by, bx + bw - 1, by + bh - 1); add_rand(10, 1);
            run_pixels();
            for (int k = 0; k < px_x.size(); k++) begin
                e = ref_color(px_x[k], px_y[k]); hit_step(px_x[k], px_y[k]);
                n_total++;
                if (obs[k] !== e) $display("FAIL hit_px%0d (%0d,%0d) got %h want %h", round, px_x[k], px_y[k], obs[k], e);
                else n_pass++;
            end
            commit_frame(fd1, fd2, hv, hr, hc);
            n_total++; if (hv !== 1'(m_hv)) $display("FAIL hit_hv%0d got %b want %b", round, hv, m_hv); else n_pass++;
            n_total++; if (hr !== 3'(m_hrow)) $display("FAIL hit_row%0d got %0d want %0d", round, hr, m_hrow); else n_pass++;
            n_total++; if (hc !== 4'(m_hcol)) $display("FAIL hit_col%0d got %0d want %0d", round, hc, m_hcol); else n_pass++;
            if (round < 2) begin
                n_total++;
                if (hv !== (round == 0) || hr !== 3'd0 || hc !== 4'd1)
                    $display("FAIL hit_fixed%0d got v=%b r=%0d c=%0d want v=%b r=0 c=1", round, hv, hr, hc, round == 0);
                else n_pass++;
            end
        end
    endtask

    task automatic test_clr_restore();
        logic fd1, fd2, hv; logic [2:0] hr; logic [3:0] hc; logic [7:0] e;
        write_obj(0, 0, 0, 0, 0, 0, 1'b0);
        commit_frame(fd1, fd2, hv, hr, hc);
        brick_op(1'b1, 1'b0, 3, 4);
        brick_op(1'b1, 1'b1, 6, 2);
        px_x.delete(); px_y.delete();
        for (int r = 0; r < 8; r++) for (int c = 0; c < 16; c++) add_px(64 + 32 * c + 16, 96 + 8 * r + 4);
        run_pixels();
        for (int k = 0; k < px_x.size(); k++) begin
            e = ref_color(px_x[k], px_y[k]); hit_step(px_x[k], px_y[k]);
            n_total++;
            if (obs[k] !== 8'hE0 || obs[k] !== e) $display("FAIL restore_px (%0d,%0d) got %h want e0", px_x[k], px_y[k], obs[k]);
            else n_pass++;
        end
        // Clear issued on the edge that samples the same cell: that pixel keeps the brick
        X_PIXEL = 10'd355; Y_PIXEL = 10'd138;
        BRICK_CLR = 1'b1; BRICK_ROW = 3'd5; BRICK_COL = 4'd9;
        @(posedge CLK); #1;
        BRICK_CLR = 1'b0;
        @(posedge CLK); #1;
        n_total++; if (COLOR_OUT !== 8'hE0) $display("FAIL clr_inflight got %h want e0", COLOR_OUT); else n_pass++;
        set_filler();
        bm[5][9] = 1'b0;
        @(posedge CLK); #1;
        e = ref_color(355, 138);
        n_total++; if (COLOR_OUT !== e) $display("FAIL clr_after got %h want %h", COLOR_OUT, e); else n_pass++;
    endtask

    task automatic test_wrap();
        logic fd1, fd2, hv; logic [2:0] hr; logic [3:0] hc; logic [7:0] e;
        write_obj(2, 1000, 0, 100, 600, 8'h55, 1'b1);
        commit_frame(fd1, fd2, hv, hr, hc);
        px_x.delete(); px_y.delete();
        for (int i = 0; i < 50; i++) add_px($urandom_range(0, 99), $urandom_range(0, 599));
        add_px(0, 100); add_px(99, 120); add_px(1010, 100);
        run_pixels();
        for (int k = 0; k < px_x.size(); k++) begin
            e = ref_color(px_x[k], px_y[k]); hit_step(px_x[k], px_y[k]);
            n_total++;
            if (obs[k] === 8'h55 || obs[k] !== e) $display("FAIL wrap_px (%0d,%0d) got %h want %h", px_x[k], px_y[k], obs[k], e);
            else n_pass++;
        end
        write_obj(2, 0, 0, 0, 0, 0, 1'b0);
        commit_frame(fd1, fd2, hv, hr, hc);
    endtask

    task automatic test_reset_midframe();
        logic fd1, fd2, hv; logic [2:0] hr; logic [3:0] hc; logic [7:0] e;
        write_obj(0, 165, 114, 4, 4, 8'hFF, 1'b1);
        commit_frame(fd1, fd2, hv, hr, hc);
        px_x.delete(); px_y.delete();
        add_rect(165, 114, 168, 117);
        run_pixels();
        for (int k = 0; k < px_x.size(); k++) hit_step(px_x[k], px_y[k]);
        commit_frame(fd1, fd2, hv, hr, hc);
        n_total++;
        if (hv !== 1'b1 || hr !== 3'd2 || hc !== 4'd3) $display("FAIL pre_reset_hit got v=%b r=%0d c=%0d want v=1 r=2 c=3", hv, hr, hc);
        else n_pass++;
        px_x.delete(); px_y.delete();
        add_rect(165, 114, 168, 117); add_px(300, 120);
        run_pixels();
        // Rewind the output to the last pixel: stage 2 still holds (300,120)
        n_total++; if (obs[obs.size() - 1] !== 8'hE0) $display("FAIL pre_reset_color got %h want e0", obs[obs.size() - 1]); else n_pass++;
        RESET = 1'b1;
        #1;
        n_total++; if (COLOR_OUT !== 8'h00) $display("FAIL async_color got %h want 00", COLOR_OUT); else n_pass++;
        n_total++; if (HIT_VALID !== 1'b0) $display("FAIL async_hv got %b want 0", HIT_VALID); else n_pass++;
        n_total++; if (HIT_ROW !== 3'd0) $display("FAIL async_row got %0d want 0", HIT_ROW); else n_pass++;
        n_total++; if (HIT_COL !== 4'd0) $display("FAIL async_col got %0d want 0", HIT_COL); else n_pass++;
        n_total++; if (FRAME_DONE !== 1'b0) $display("FAIL async_fd got %b want 0", FRAME_DONE); else n_pass++;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
        px_x.delete(); px_y.delete();
        add_rect(165, 114, 168, 117); add_px(355, 138); add_px(400, 500);
        run_pixels();
        for (int k = 0; k < px_x.size(); k++) begin
            e = ref_color(px_x[k], px_y[k]); hit_step(px_x[k], px_y[k]);
            n_total++;
            if (obs[k] !== e) $display("FAIL post_reset_px (%0d,%0d) got %h want %h", px_x[k], px_y[k], obs[k], e);
            else n_pass++;
        end
        commit_frame(fd1, fd2, hv, hr, hc);
        n_total++; if (fd1 !== 1'b1 || hv !== 1'b0) $display("FAIL post_reset_frame got fd=%b hv=%b want fd=1 hv=0", fd1, hv); else n_pass++;
    endtask

    initial begin
        RESET = 1'b1; OBJ_WE = 1'b0; OBJ_SEL = '0; OBJ_X = '0; OBJ_Y = '0; OBJ_W = '0; OBJ_H = '0;
        OBJ_COLOR = '0; OBJ_EN = 1'b0; BRICK_CLR = 1'b0; BRICK_ROW = '0; BRICK_COL = '0;
        BRICK_RESTORE = 1'b0;
        set_filler();
        model_reset();
        test_reset();
        test_empty_frame();
        test_obj_midframe();
        test_priority();
        test_hit();
        test_clr_restore();
        test_wrap();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/layered_renderer.md
# layered_renderer

Parametrised successor to the single-colour game renderer. Composites up to NUM_OBJ coloured rectangles (ball, paddle, housing segments) over a ROWS×COLS brick bitmap for each pixel the SVGA interface requests. Object attributes are double-buffered and commit atomically at the frame boundary. The block reports the first ball-to-brick overlap of each frame to the game logic. It sits between the game-state logic and the SVGA interface and is driven by the interface's X/Y pixel counters.

## Interface
Parameters:
- NUM_OBJ, 4: number of rectangle object slots; slot 0 is the ball.
- SEL_W, 2: width of OBJ_SEL; 2**SEL_W ≥ NUM_OBJ.
- ROWS, 8: brick rows.
- COLS, 16: brick columns.
- BRICK_X0, 64: pixel X of the brick field's left edge.
- BRICK_Y0, 96: pixel Y of the brick field's top edge.
- BW_LOG2, 5: log2 of brick width in px (32).
- BH_LOG2, 3: log2 of brick height in px (8).
- ACTIVE_W, 800: visible width in px.
- ACTIVE_H, 600: visible height in px.
- BRICK_COLOR, 8'hE0: brick pixel colour.
- BG_COLOR, 8'h00: background colour.

Ports:
- CLK  in  1  pixel clock.
- RESET  in  1  reset; asynchronous, active-high.
- X_PIXEL  in  10  current pixel X from the SVGA interface.
- Y_PIXEL  in  10  current pixel Y from the SVGA interface.
- OBJ_WE  in  1  write strobe for the shadow object slot selected by OBJ_SEL.
- OBJ_SEL  in  SEL_W  slot index; writes with index ≥ NUM_OBJ are ignored.
- OBJ_X, OBJ_Y  in  10 each  top-left corner of the object.
- OBJ_W, OBJ_H  in  10 each  object size in px; 0 means not drawn.
- OBJ_COLOR  in  8  object colour.
- OBJ_EN  in  1  object enable.
- BRICK_CLR  in  1  clears the active brick bit at BRICK_ROW/BRICK_COL.
- BRICK_ROW  in  $clog2(ROWS)  row index for BRICK_CLR.
- BRICK_COL  in  $clog2(COLS)  column index for BRICK_CLR.
- BRICK_RESTORE  in  1  sets all brick bits to 1.
- COLOR_OUT  out  8  composited colour to the SVGA interface.
- FRAME_DONE  out  1  one-cycle frame-boundary pulse.
- HIT_VALID  out  1  pulses with FRAME_DONE if a ball-to-brick hit occurred in the frame.
- HIT_ROW  out  $clog2(ROWS)  row of the first hit; held until the next FRAME_DONE.
- HIT_COL  out  $clog2(COLS)  column of the first hit; held until the next FRAME_DONE.

## Operation
- Object slots
  - Each slot has a shadow register set and an active register set.
  - OBJ_WE writes the shadow set only.
  - The shadow→active copy of all slots happens on the edge that samples X_PIXEL=0, Y_PIXEL=ACTIVE_H. This is the commit edge.
  - An OBJ_WE on the commit edge updates the shadow set. The active set receives the pre-edge shadow values, so that write takes effect one frame later.
- Object hit test
  - Pixel (x,y) is inside an active slot when EN=1 and X≤x<X+W and Y≤y<Y+H.
  - The sums are computed at 11 bits, so there is no wrap-around.
- Brick cell
  - col = (x−BRICK_X0)>>BW_LOG2, row = (y−BRICK_Y0)>>BH_LOG2.
  - A brick is drawn only if x≥BRICK_X0, y≥BRICK_Y0, col<COLS, row<ROWS, and the bitmap bit is 1.
- Priority
  - The lowest-index active slot that hits wins.
  - Otherwise BRICK_COLOR if a brick is drawn, else BG_COLOR.
  - Outside x<ACTIVE_W and y<ACTIVE_H the output is 8'h00.
- Brick bitmap
  - BRICK_CLR takes effect on the next edge.
  - If BRICK_RESTORE and BRICK_CLR are asserted together, RESTORE wins and all bits become 1.
  - The bitmap is not double-buffered.
- Hit detection
  - Checked in the visible area only.
  - A hit is a pixel that is inside active slot 0 and inside a drawn brick.
  - The first such pixel of the frame latches its row/col into the pending registers and sets the pending flag. Later hits in the same frame are ignored.
  - On the commit edge: HIT_VALID ← pending, HIT_ROW/COL ← pending row/col (only if pending), and pending is cleared.
- Reset
  - COLOR_OUT=0, FRAME_DONE=0, HIT_VALID=0, HIT_ROW=0, HIT_COL=0.
  - All shadow and active slots are zeroed, with EN=0.
  - Bitmap is all ones; pending is clear.
  - Reset asserted mid-frame applies immediately; output resumes with the next sampled pixel after release.

## Timing
- Pipeline
  - Stage 1 registers the per-slot hit vector, the brick-drawn flag and the cell indices.
  - Stage 2 registers COLOR_OUT.
  - COLOR_OUT for pixel (x,y) appears 2 cycles after X_PIXEL/Y_PIXEL present (x,y).
  - The SVGA interface's pixel offset is compensated by the integrator, not in this block.
- Commit and FRAME_DONE
  - FRAME_DONE is high for exactly one cycle, starting 1 cycle after X_PIXEL=0, Y_PIXEL=ACTIVE_H is sampled.
  - HIT_VALID is coincident with FRAME_DONE.
- Brick writes
  - A BRICK_CLR issued during the visible area affects pixels sampled after its edge.
  - Pixels already in the pipeline keep the old value.
- Hit latching
  - Uses stage-1 data, so the hit for a pixel latches 1 cycle after that pixel is sampled.
  - No visible pixel can coincide with the commit edge.

## Test plan
- Reset, then sweep one frame with no objects enabled. Required: brick field pixels (64..575, 96..159) = 8'hE0, all other visible pixels = 8'h00, one FRAME_DONE per frame, HIT_VALID=0.
- Write slot 1 (X=100, Y=100, W=H=8, color 8'h1C, EN=1) mid-frame. Required: nothing is drawn this frame; pixels 100..107 × 100..107 are 8'h1C from the next frame on; pixel 108 stays 8'hE0.
- Slots 0 and 1 overlap at (200,300) with colors 8'hFF and 8'h03. Required: overlap pixels are 8'hFF. Disabling slot 0 makes them 8'h03 after the next commit.
- Ball (slot 0) at (96,96), 4×4, EN=1. Required: HIT_VALID=1 with the next FRAME_DONE, HIT_ROW=0, HIT_COL=1. Then BRICK_CLR row 0, col 1 → no hit in the following frame, HIT_ROW/COL hold their values.
- BRICK_CLR and BRICK_RESTORE on the same edge. Required: all bricks drawn.
- Assert RESET mid-frame. Required: all outputs 0 within 0 cycles (asynchronous), slots disabled, bitmap full.
- Slot with X=1000, W=100. Required: no wrap artefact at x<100.
